// File: rtl/multi_key_pulse.sv
// N-channel key front end: synchroniser, per-channel debounce, press/release pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses.
module multi_key_pulse #(
    parameter int unsigned N               = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
`endif
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic [N-1:0] in_i,
    output logic [N-1:0] out_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] level_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  s;
    logic [N-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0]                  level_q, level_d;
    logic [N-1:0]                  out_q, out_d;
    logic [N-1:0]                  rel_q, rel_d;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RW = $clog2(RepMax + 1);
    localparam logic [RW-1:0] RepFirst = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RepNext  = RW'(REPEAT_PERIOD - 1);

    logic [N-1:0][RW-1:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        out_d   = '0;
        rel_d   = '0;
`ifdef AUTO_REPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        for (int i = 0; i < int'(N); i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                out_d[i]   = s[i];
                rel_d[i]   = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
`ifdef AUTO_REPEAT_EN
            // Down-counter to the next repeat; reloaded on press, held clear while released.
            if (!level_d[i]) begin
                rcnt_d[i] = '0;
            end else if (!level_q[i]) begin
                rcnt_d[i] = RepFirst;
            end else if (rcnt_q[i] == '0) begin
                out_d[i]  = 1'b1;
                rcnt_d[i] = RepNext;
            end else begin
                rcnt_d[i] = rcnt_q[i] - RW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            out_q   <= '0;
            rel_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            out_q   <= out_d;
            rel_q   <= rel_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`endif

    assign out_o     = out_q;
    assign release_o = rel_q;
    assign level_o   = level_q;

endmodule

// File: tb/tb_multi_key_pulse.sv
// Scoreboard bench for multi_key_pulse (N=4, 2 sync stages, 4-cycle debounce).
// Repeat scenario is built only when AUTO_REPEAT_EN is defined (delay 5, period 3).
module tb_multi_key_pulse;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 5;
    localparam int RP   = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_in;
    logic [3:0] out, rel, level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q[$];
    logic [3:0]  m_sync[SYNC];
    logic [3:0]  m_level;
    int          m_run[4];
    int          m_age[4];

    always #5 clk = ~clk;

    multi_key_pulse #(
        .N(4),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_n),
        .in_i(key_in),
        .out_o(out),
        .release_o(rel),
        .level_o(level)
    );

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
        m_level = '0;
        for (int c = 0; c < 4; c++) begin
            m_run[c] = 0;
            m_age[c] = 0;
        end
        exp_q.delete();
    endtask

    // Level flips once DEB consecutive synced samples disagree with it.
    task automatic model_step(input logic [3:0] v);
        logic [3:0] sv, o, r;
        sv = m_sync[SYNC-1];
        o  = '0;
        r  = '0;
        for (int c = 0; c < 4; c++) begin
            if (sv[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_level[c] = sv[c];
                    m_run[c]   = 0;
                    o[c]       = sv[c];
                    r[c]       = ~sv[c];
                    m_age[c]   = 0;
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef AUTO_REPEAT_EN
            if (m_level[c] && !o[c]) begin
                m_age[c]++;
                if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) o[c] = 1'b1;
            end
`endif
        end
        for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = v;
        exp_q.push_back({o, r, m_level});
    endtask

    task automatic test_reset();
        logic [11:0] exp, got;
        reset_n = 1'b0;
        key_in  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({out, rel, level} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 000", {out, rel, level});
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            key_in = 4'hF;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_pre cyc %0d: got %h want %h", i, got, exp);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({out, rel, level} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 000", {out, rel, level});
        end
        model_reset();
        @(negedge clk);
        key_in  = 4'h0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== 12'h000 || got !== exp) begin
                n_fail++;
                $display("FAIL reset_post cyc %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [11:0] exp, got;
        int first, pulses;
        first  = -1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            key_in = 4'b0001;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL press cyc %0d: got %h want %h", i, got, exp);
            end
            if (out[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_tests++;
        if (first != SYNC + DEB - 1) begin
            n_fail++;
            $display("FAIL press_latency: got %0d want %0d", first, SYNC + DEB - 1);
        end
        n_tests++;
        if (level[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL press_level: got %b want 1", level[0]);
        end
`ifndef AUTO_REPEAT_EN
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL press_single: got %0d pulses want 1", pulses);
        end
`endif
    endtask

    task automatic test_release();
        logic [11:0] exp, got;
        int first, outs;
        first = -1;
        outs  = 0;
        for (int i = 0; i < 12; i++) begin
            key_in = 4'b0000;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL release cyc %0d: got %h want %h", i, got, exp);
            end
            if (rel[0] && first < 0) first = i;
            if (out[0]) outs++;
        end
        n_tests++;
        if (first != SYNC + DEB - 1 || level[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_latency: got %0d lvl %b want %0d lvl 0",
                     first, level[0], SYNC + DEB - 1);
        end
`ifndef AUTO_REPEAT_EN
        n_tests++;
        if (outs != 0) begin
            n_fail++;
            $display("FAIL release_no_out: got %0d want 0", outs);
        end
`endif
    endtask

    task automatic test_bounce();
        logic [11:0] exp, got;
        logic [4:0]  pat;
        int hits;
        pat  = 5'b01101;  // applied LSB first: 1,0,1,1,0
        hits = 0;
        for (int i = 0; i < 13; i++) begin
            key_in = (i < 5) ? {2'b00, pat[i], 1'b0} : 4'b0000;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: got %h want %h", i, got, exp);
            end
            if (out[1] || level[1]) hits++;
        end
        n_tests++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL bounce_filtered: got %0d active cycles want 0", hits);
        end
    endtask

    task automatic test_min_width();
        logic [11:0] exp, got;
        int press_at, rel_at, short_hits;
        press_at   = -1;
        rel_at     = -1;
        short_hits = 0;
        for (int i = 0; i < 31; i++) begin
            // 3-cycle pulse, gap, then a 4-cycle pulse on channel 3
            key_in = ((i < 3) || (i >= 11 && i < 15)) ? 4'b1000 : 4'b0000;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL minwidth cyc %0d: got %h want %h", i, got, exp);
            end
            if (i < 11 && (out[3] || level[3])) short_hits++;
            if (i >= 11 && out[3] && press_at < 0) press_at = i - 11;
            if (i >= 11 && rel[3] && rel_at < 0) rel_at = i - 11;
        end
        n_tests++;
        if (short_hits != 0 || press_at != 5 || rel_at != 9) begin
            n_fail++;
            $display("FAIL minwidth_timing: got short %0d press %0d rel %0d want 0 5 9",
                     short_hits, press_at, rel_at);
        end
    endtask

    task automatic test_multi();
        logic [11:0] exp, got;
        int together;
        together = -1;
        for (int i = 0; i < 20; i++) begin
            key_in = (i < 10) ? 4'b1010 : 4'b0000;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL multi cyc %0d: got %h want %h", i, got, exp);
            end
            if (i < 10 && out != 4'b0000) together = (out == 4'b1010 && i == 5) ? i : 99;
        end
        n_tests++;
        if (together != 5) begin
            n_fail++;
            $display("FAIL multi_together: got cycle %0d want 5", together);
        end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_repeat();
        logic [11:0] exp, got;
        logic want;
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            key_in = (i < 20) ? 4'b0100 : 4'b0000;
            model_step(key_in);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {out, rel, level};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL repeat cyc %0d: got %h want %h", i, got, exp);
            end
            want = (i == 5 || i == 10 || i == 13 || i == 16 || i == 19 || i == 22);
            if (out[2] !== want) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL repeat_times: got %0d wrong cycles want 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_min_width();
        test_multi();
`ifdef AUTO_REPEAT_EN
        test_repeat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
